// File: rtl/sfp_norm.sv
// Row normaliser: absolute-sum accumulate, optional peer-sum exchange, bit-serial divide.
// Define SFP_DUAL_CORE_EN to enable the XCHG handshake with the peer core.
module sfp_norm #(
  parameter int col     = 8,
  parameter int bw_psum = 20,
  parameter int frac    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [bw_psum*col-1:0]   in,
  input  logic                     in_valid,
  input  logic [bw_psum+3:0]       sum_in,
  input  logic                     sum_in_valid,
  output logic [bw_psum+3:0]       sum_out,
  output logic                     sum_out_valid,
  output logic [bw_psum*col-1:0]   out,
  output logic                     out_valid,
  output logic                     busy
);

  localparam int SW = bw_psum + 4;
  localparam int MW = bw_psum + 1;
  localparam int RW = bw_psum + 5;
  localparam int QW = frac + 1;
  localparam int CW = (frac + 1 > 1) ? $clog2(frac + 1) : 1;

  typedef enum logic [2:0] {IDLE, ACC, XCHG, DIV, DONE} state_t;

  state_t              state;
  logic [MW-1:0]       mag    [col];
  logic                sgn    [col];
  logic [RW-1:0]       rem    [col];
  logic [frac-1:0]     quo    [col];
  logic [SW-1:0]       total;
  logic [CW-1:0]       cnt;

  logic [MW-1:0]       in_mag [col];
  logic                in_sgn [col];
  logic [RW-1:0]       rem_sh [col];
  logic [RW-1:0]       rem_nx [col];
  logic                qbit   [col];
  logic [QW-1:0]       quo_nx [col];
  logic [bw_psum-1:0]  out_nx [col];
  logic [SW-1:0]       local_sum;
  logic [RW-1:0]       total_ext;
  logic                first;

  assign busy      = (state != IDLE);
  assign total_ext = {1'b0, total};
  assign first     = (cnt == CW'(frac));

  always_comb begin
    local_sum = '0;
    for (int i = 0; i < col; i++)
      local_sum = local_sum + SW'(mag[i]);
  end

  for (genvar gi = 0; gi < col; gi++) begin : g_elem
    logic [bw_psum-1:0] x;
    logic [MW-1:0]      xe;
    logic [bw_psum-1:0] q_ext;

    // One extra bit keeps |-2^(bw_psum-1)| exact.
    assign x          = in[bw_psum*gi +: bw_psum];
    assign xe         = {x[bw_psum-1], x};
    assign in_mag[gi] = xe[MW-1] ? (~xe + 1'b1) : xe;
    assign in_sgn[gi] = x[bw_psum-1];

    assign rem_sh[gi] = first ? rem[gi] : {rem[gi][RW-2:0], 1'b0};
    assign qbit[gi]   = (rem_sh[gi] >= total_ext);
    assign rem_nx[gi] = qbit[gi] ? (rem_sh[gi] - total_ext) : rem_sh[gi];
    assign quo_nx[gi] = {quo[gi], qbit[gi]};

    assign q_ext      = {{(bw_psum-QW){1'b0}}, quo_nx[gi]};
    assign out_nx[gi] = (total == '0) ? '0 : (sgn[gi] ? (-q_ext) : q_ext);
  end

`ifndef SFP_DUAL_CORE_EN
  logic unused_peer;
  assign unused_peer = ^{sum_in, sum_in_valid};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      total         <= '0;
      cnt           <= '0;
      sum_out       <= '0;
      sum_out_valid <= 1'b0;
      out           <= '0;
      out_valid     <= 1'b0;
      for (int i = 0; i < col; i++) begin
        mag[i] <= '0;
        sgn[i] <= 1'b0;
        rem[i] <= '0;
        quo[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < col; i++) begin
              mag[i] <= in_mag[i];
              sgn[i] <= in_sgn[i];
            end
            state <= ACC;
          end
        end
        ACC: begin
          sum_out <= local_sum;
          total   <= local_sum;
          cnt     <= CW'(frac);
          for (int i = 0; i < col; i++) begin
            rem[i] <= {{(RW-MW){1'b0}}, mag[i]};
            quo[i] <= '0;
          end
`ifdef SFP_DUAL_CORE_EN
          sum_out_valid <= 1'b1;
          state         <= XCHG;
`else
          state         <= DIV;
`endif
        end
        XCHG: begin
          if (sum_in_valid) begin
            total         <= sum_out + sum_in;
            sum_out_valid <= 1'b0;
            state         <= DIV;
          end
        end
        DIV: begin
          for (int i = 0; i < col; i++) begin
            rem[i] <= rem_nx[i];
            quo[i] <= quo_nx[i][frac-1:0];
          end
          // The final quotient bit goes straight to the output register.
          if (cnt == '0) begin
            for (int i = 0; i < col; i++)
              out[bw_psum*i +: bw_psum] <= out_nx[i];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (in_valid) begin
            for (int i = 0; i < col; i++) begin
              mag[i] <= in_mag[i];
              sgn[i] <= in_sgn[i];
            end
            state <= ACC;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sfp_norm.sv
// Scoreboard bench for sfp_norm: random rows against an arithmetic model of the normalisation.
module tb_sfp_norm;
  localparam int COL  = 8;
  localparam int BW   = 20;
  localparam int FRAC = 8;
  localparam int SW   = BW + 4;
  localparam int VW   = BW * COL;
`ifdef SFP_DUAL_CORE_EN
  localparam bit DUAL = 1'b1;
  localparam int LAT  = FRAC + 4;
`else
  localparam bit DUAL = 1'b0;
  localparam int LAT  = FRAC + 3;
`endif

  typedef struct {
    logic [SW-1:0] sum;
    logic [VW-1:0] outv;
    longint        edge_at;
    int            sov;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [VW-1:0] in_bus;
  logic          in_valid;
  logic [SW-1:0] sum_in;
  logic          sum_in_valid;
  logic [SW-1:0] sum_out;
  logic          sum_out_valid;
  logic [VW-1:0] out_bus;
  logic          out_valid;
  logic          busy;

  int     errors = 0;
  int     checks = 0;
  longint edge_cnt = 0;
  int     sov_cnt = 0;
  exp_t   exp_q[$];

  sfp_norm #(.col(COL), .bw_psum(BW), .frac(FRAC)) dut (
    .clk(clk), .reset(reset), .in(in_bus), .in_valid(in_valid),
    .sum_in(sum_in), .sum_in_valid(sum_in_valid),
    .sum_out(sum_out), .sum_out_valid(sum_out_valid),
    .out(out_bus), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, expv);
    end
  endtask

  // Reference: q_i = floor(|x_i| * 2^frac / total), signed like x_i, zero if total is zero.
  task automatic model(input logic [VW-1:0] row, input longint peer,
                       output logic [SW-1:0] s_out, output logic [VW-1:0] o);
    longint a[COL];
    longint s, total, q, v;
    logic signed [BW-1:0] xe;
    s = 0;
    o = '0;
    for (int i = 0; i < COL; i++) begin
      xe   = row[BW*i +: BW];
      a[i] = (xe < 0) ? -longint'(xe) : longint'(xe);
      s   += a[i];
    end
    total = DUAL ? ((s + peer) % (longint'(1) << SW)) : s;
    for (int i = 0; i < COL; i++) begin
      xe = row[BW*i +: BW];
      q  = (total == 0) ? 0 : ((a[i] << FRAC) / total);
      v  = (xe < 0) ? -q : q;
      o[BW*i +: BW] = v[BW-1:0];
    end
    s_out = s[SW-1:0];
  endtask

  function automatic logic [VW-1:0] mkrow(input int v0, input int v1, input int rest);
    logic [VW-1:0] r;
    logic [31:0] t;
    for (int i = 0; i < COL; i++) begin
      t = (i == 0) ? v0 : (i == 1) ? v1 : rest;
      r[BW*i +: BW] = t[BW-1:0];
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] rndrow();
    logic [VW-1:0] r;
    logic [31:0] t;
    int mode;
    mode = $urandom_range(0, 2);
    for (int i = 0; i < COL; i++) begin
      if (mode == 0) t = $urandom;
      else if (mode == 1) t = 32'($urandom_range(0, 40)) - 32'd20;
      else t = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
      r[BW*i +: BW] = t[BW-1:0];
    end
    return r;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=1 after %0d cycles, required 0", n);
    end
  endtask

  task automatic issue(input logic [VW-1:0] row, input longint peer, input int delay,
                       input bit push, input bit noise);
    exp_t e;
    longint e0;
    wait_idle();
    @(negedge clk);
    in_bus       = row;
    in_valid     = 1'b1;
    sum_in       = peer[SW-1:0];
    sum_in_valid = DUAL ? 1'b0 : 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    e0       = edge_cnt;
    in_valid = 1'b0;
    if (push) begin
      model(row, peer, e.sum, e.outv);
      e.edge_at = e0 + LAT - 1 + (DUAL ? delay : 0);
      e.sov     = DUAL ? delay + 1 : 0;
      exp_q.push_back(e);
    end
    chk("busy_after_sample", VW'(busy), VW'(1));
    if (DUAL) begin
      repeat (delay + 1) @(posedge clk);
      @(negedge clk);
      sum_in_valid = 1'b1;
      @(posedge clk);
      #1;
      sum_in_valid = 1'b0;
    end
    if (noise) begin
      @(negedge clk);
      in_bus   = rndrow();
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic back_to_back(input logic [VW-1:0] ra, input logic [VW-1:0] rb, input longint peer);
    exp_t e;
    longint e0;
    wait_idle();
    @(negedge clk);
    in_bus       = ra;
    in_valid     = 1'b1;
    sum_in       = peer[SW-1:0];
    sum_in_valid = DUAL;
    @(posedge clk);
    #1;
    e0 = edge_cnt;
    model(ra, peer, e.sum, e.outv);
    e.edge_at = e0 + LAT - 1;
    e.sov     = DUAL ? 1 : 0;
    exp_q.push_back(e);
    @(negedge clk);
    in_bus = rb;
    while (edge_cnt < e0 + LAT) @(posedge clk);
    #1;
    in_valid = 1'b0;
    model(rb, peer, e.sum, e.outv);
    e.edge_at = e0 + 2 * LAT - 1;
    exp_q.push_back(e);
    repeat (3) @(posedge clk);
    #1;
    sum_in_valid = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_out"}, out_bus, '0);
    chk({tag, "_sum_out"}, VW'(sum_out), '0);
    chk({tag, "_out_valid"}, VW'(out_valid), '0);
    chk({tag, "_sum_out_valid"}, VW'(sum_out_valid), '0);
    chk({tag, "_busy"}, VW'(busy), '0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sov_cnt = 0;
    end else begin
      if (sum_out_valid) sov_cnt++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out_valid: got out_valid=1 at edge %0d, required 0", edge_cnt);
        end else begin
          e = exp_q.pop_front();
          $display("row done edge=%0d sum_out=%0d out=%h", edge_cnt, sum_out, out_bus);
          chk("out", out_bus, e.outv);
          chk("sum_out", VW'(sum_out), VW'(e.sum));
          chk("latency_edge", VW'(edge_cnt), VW'(e.edge_at));
          chk("sum_out_valid_cycles", VW'(sov_cnt), VW'(e.sov));
        end
        sov_cnt = 0;
      end
    end
  end

  initial begin
    int n;
    reset        = 1'b1;
    in_bus       = '0;
    in_valid     = 1'b0;
    sum_in       = '0;
    sum_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    reset = 1'b0;

    issue(mkrow(1, 1, 1), 0, 0, 1'b1, 1'b0);
    issue(mkrow(-3, 1, 0), 4, 0, 1'b1, 1'b0);
    issue(mkrow(-3, 1, 0), 4, 5, 1'b1, 1'b1);
    issue(mkrow(0, 0, 0), 0, 0, 1'b1, 1'b0);
    issue(mkrow(-524288, 0, 0), 0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++)
      issue(rndrow(), longint'($urandom_range(0, 1 << 22)), $urandom_range(0, 3), 1'b1,
            1'($urandom_range(0, 1)));
    back_to_back(rndrow(), mkrow(7, -9, 2), 100);

    // Abort a row mid-divide: outputs clear at once and the row never completes.
    issue(mkrow(5, -6, 7), 11, 0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_cleared("abort");
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);

    for (int i = 0; i < 5; i++)
      issue(rndrow(), longint'($urandom_range(0, 1000)), $urandom_range(0, 2), 1'b1, 1'b0);

    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d rows outstanding, required 0", exp_q.size());
    end
    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
